// File: rtl/lc3b_muldiv.sv
// lc3b_muldiv: iterative unsigned multiply/divide for the LC-3b execute stage.
// One operand bit per cycle: shift-add multiply (LSB first), restoring divide.
// The accumulator is split into hi_q/lo_q:
//   multiply: {hi_q, lo_q} is the running 2*width product;
//   divide:   hi_q is the partial remainder, lo_q collects quotient bits.
module lc3b_muldiv #(
   parameter int width = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [width-1:0] a,
   input  logic [width-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [width-1:0] result
);

   localparam int CW = (width > 1) ? $clog2(width) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state_q, state_d;
   logic [1:0]       op_q;
   logic [width-1:0] a_q, b_q;
   logic [width-1:0] hi_q, lo_q;
   logic [CW-1:0]    cnt_q;
   logic             last;

   logic [width:0]   msum;
   logic [width:0]   dshift;
   logic [width+1:0] dtrial;
   logic             dborrow;
   logic [width-1:0] hi_n, lo_n;

   assign last = (cnt_q == CW'(width-1));

   // One iteration of the selected algorithm, computed from the current accumulator
   always_comb begin
      // multiply: conditional add into the upper half, carry kept in bit width
      msum   = b_q[cnt_q] ? ({1'b0, hi_q} + {1'b0, a_q}) : {1'b0, hi_q};
      // divide: bring the next dividend bit (MSB first) into the remainder
      dshift = {hi_q, a_q[CW'(width-1) - cnt_q]};
      dtrial = {1'b0, dshift} - {2'b0, b_q};
      // a set bit width in the difference only ever occurs together with a borrow
      dborrow = dtrial[width+1] | dtrial[width];
      hi_n = '0;
      lo_n = '0;
      if (op_q[1]) begin
         hi_n = dborrow ? dshift[width-1:0] : dtrial[width-1:0];
         lo_n = {lo_q[width-2:0], ~dborrow};
      end else begin
         hi_n = msum[width:1];
         lo_n = {msum[0], lo_q[width-1:1]};
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic: IDLE -> BUSY on start, BUSY for width cycles, DONE for one
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = BUSY;
         BUSY:    if (last)  state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Registered handshake outputs, decoded from the next state
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy <= 1'b0;
         done <= 1'b0;
      end else begin
         busy <= (state_d == BUSY);
         done <= (state_d == DONE);
      end
   end

   // Operand latch, accumulator iteration, and result load on entry to DONE
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
         cnt_q  <= '0;
         result <= '0;
      end else begin
         case (state_q)
            IDLE: if (start) begin
               op_q  <= op;
               a_q   <= a;
               b_q   <= b;
               hi_q  <= '0;
               lo_q  <= '0;
               cnt_q <= '0;
            end
            BUSY: begin
               hi_q  <= hi_n;
               lo_q  <= lo_n;
               cnt_q <= last ? '0 : cnt_q + 1'b1;
               // op[0] picks the upper half: product high word or remainder
               if (last) result <= op_q[0] ? hi_n : lo_n;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_lc3b_muldiv.sv
// Directed bench for lc3b_muldiv: vector table plus multi-cycle corner sequences.
module tb_lc3b_muldiv;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [15:0] a, b;
   logic        busy, done;
   logic [15:0] result;

   int ntests = 0;
   int nfail  = 0;

   lc3b_muldiv #(.width(16)) dut (
      .clk(clk), .reset(reset), .start(start), .op(op),
      .a(a), .b(b), .busy(busy), .done(done), .result(result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [1:0]  op;
      logic [15:0] exp;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ntests++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // edges from the current point until done is seen, bounded
   task automatic wait_done(output int n);
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
   endtask

   // Full transaction from IDLE: latency, busy/done behaviour and result
   task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_,
                         input logic [1:0] top, input logic [15:0] texp,
                         input string nm);
      int n;
      a = ta; b = tb_; op = top; start = 1'b1;
      @(posedge clk); #1;              // E0
      start = 1'b0;
      chk({nm, " busy after start"}, {31'b0, busy}, 32'd1);
      wait_done(n);
      chk({nm, " latency edges"}, n, 32'd16);
      chk({nm, " result"}, {16'b0, result}, {16'b0, texp});
      chk({nm, " busy low in done"}, {31'b0, busy}, 32'd0);
      @(posedge clk); #1;              // E17
      chk({nm, " done one cycle"}, {31'b0, done}, 32'd0);
   endtask

   initial begin
      int n, ndone;
      logic [15:0] got;

      vecs.push_back('{16'h0003, 16'h0005, 2'b00, 16'h000F, "mulu 3*5 lo"});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 2'b01, 16'hFFFE, "mulu ffff hi"});
      vecs.push_back('{16'hFFFF, 16'hFFFF, 2'b00, 16'h0001, "mulu ffff lo"});
      vecs.push_back('{16'h0064, 16'h0007, 2'b10, 16'h000E, "divu 100/7"});
      vecs.push_back('{16'h0064, 16'h0007, 2'b11, 16'h0002, "remu 100%7"});
      vecs.push_back('{16'h1234, 16'h0000, 2'b10, 16'hFFFF, "divu by 0"});
      vecs.push_back('{16'h1234, 16'h0000, 2'b11, 16'h1234, "remu by 0"});
      vecs.push_back('{16'hFFFF, 16'h0001, 2'b10, 16'hFFFF, "divu ffff/1"});
      vecs.push_back('{16'hFFFF, 16'h0001, 2'b11, 16'h0000, "remu ffff%1"});
      vecs.push_back('{16'h8000, 16'h0002, 2'b01, 16'h0001, "mulu carry hi"});
      vecs.push_back('{16'h1234, 16'h0100, 2'b01, 16'h0012, "mulu shift hi"});
      vecs.push_back('{16'h1234, 16'h0100, 2'b00, 16'h3400, "mulu shift lo"});
      vecs.push_back('{16'h3039, 16'h007B, 2'b10, 16'h0064, "divu 12345/123"});
      vecs.push_back('{16'h3039, 16'h007B, 2'b11, 16'h002D, "remu 12345%123"});

      reset = 1'b1; start = 1'b0; op = 2'b00; a = '0; b = '0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset busy",   {31'b0, busy}, 32'd0);
      chk("reset done",   {31'b0, done}, 32'd0);
      chk("reset result", {16'b0, result}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("idle no busy", {31'b0, busy}, 32'd0);

      foreach (vecs[i]) run_op(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp, vecs[i].name);

      // result holds in IDLE after a completed op
      run_op(16'h0003, 16'h0005, 2'b00, 16'h000F, "mulu hold");
      repeat (2) @(posedge clk);
      #1 chk("result held 3 cycles", {16'b0, result}, 32'h000F);

      // start pulses in BUSY cycles 3 and 10 must be ignored
      a = 16'd6; b = 16'd7; op = 2'b00; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;   // E0
      ndone = 0; got = '0;
      for (int e = 1; e <= 40; e++) begin
         if (e == 3 || e == 10) begin
            a = 16'h00FF; b = 16'h00FF; start = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(posedge clk); #1;
         if (done) begin ndone++; got = result; end
      end
      start = 1'b0;
      chk("ignored start done count", ndone, 32'd1);
      chk("ignored start result", {16'b0, got}, 32'h002A);

      // reset in BUSY cycle 8 clears outputs without a clock edge
      a = 16'd9; b = 16'd9; op = 2'b11; start = 1'b1;
      @(posedge clk); #1; start = 1'b0;   // E0
      repeat (7) @(posedge clk);
      #2 reset = 1'b1;
      #1;
      chk("async reset busy",   {31'b0, busy}, 32'd0);
      chk("async reset done",   {31'b0, done}, 32'd0);
      chk("async reset result", {16'b0, result}, 32'd0);
      @(posedge clk); #1 reset = 1'b0;
      run_op(16'd9, 16'd9, 2'b00, 16'h0051, "after reset 9*9");

      // start held high: back-to-back ops, one every 18 cycles
      a = 16'd2; b = 16'd3; op = 2'b00; start = 1'b1;
      @(posedge clk); #1;                 // E0
      wait_done(n);
      chk("b2b first latency", n, 32'd16);
      chk("b2b first result", {16'b0, result}, 32'h0006);
      a = 16'd4; b = 16'd5;
      n = 0;
      while (n < 40) begin
         @(posedge clk); #1;
         n++;
         if (done) break;
      end
      start = 1'b0;
      chk("b2b period", n, 32'd18);
      chk("b2b second result", {16'b0, result}, 32'h0014);
      repeat (3) @(posedge clk);
      #1 chk("b2b stops", {30'b0, busy, done}, 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

   // never both handshake outputs high
   always @(negedge clk) begin
      if (busy && done) begin
         nfail++;
         $display("FAIL busy_done_overlap: busy=%0b done=%0b required not both", busy, done);
      end
   end

endmodule
